// File: rtl/hero_write_arb_if.sv
// Channel-side and merged-side signals of the hero write arbiter.
// Defining HERO_WRITE_ARB_STATS_EN adds the per-channel txn_cnt vector.
interface hero_write_arb_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 36
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*4-1:0]      in_cycle_type;
  logic [NUM_CH*DATA_W-1:0] in_wdat;
  logic [NUM_CH-1:0]        in_clk_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               out_cycle_type;
  logic [DATA_W-1:0]        out_wdat;
  logic                     out_clk_en;
  logic [CH_W-1:0]          out_ch;
  logic [NUM_CH-1:0]        err_overlen;
`ifdef HERO_WRITE_ARB_STATS_EN
  logic [NUM_CH*16-1:0]     txn_cnt;
`endif

  modport slave (
    input  in_valid, in_cycle_type, in_wdat, in_clk_en, out_ready,
`ifdef HERO_WRITE_ARB_STATS_EN
    output txn_cnt,
`endif
    output in_ready, out_valid, out_cycle_type, out_wdat, out_clk_en, out_ch, err_overlen
  );

  modport master (
    output in_valid, in_cycle_type, in_wdat, in_clk_en, out_ready,
`ifdef HERO_WRITE_ARB_STATS_EN
    input  txn_cnt,
`endif
    input  in_ready, out_valid, out_cycle_type, out_wdat, out_clk_en, out_ch, err_overlen
  );
endinterface

// File: rtl/hero_write_arb.sv
// Merges NUM_CH hero write streams onto one port, round-robin by whole transaction.
// Optional HERO_WRITE_ARB_STATS_EN adds saturating per-channel DONE counters (txn_cnt).
module hero_write_arb #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 36,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hero_write_arb_if.slave bus
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CNT_W = $clog2(MAX_BEATS) + 1;
  localparam int unsigned ENT_W = DATA_W + 2;
  localparam logic [3:0]  CT_VALID = 4'd1;
  localparam logic [3:0]  CT_DONE  = 4'd2;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  arb_state_e       state_q, state_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  // FIFO entry layout: {is_done, clk_en, wdat}
  logic [ENT_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q [NUM_CH];
  logic [PW-1:0]    rd_ptr_q [NUM_CH];
  logic [CNT_W-1:0] beat_cnt_q [NUM_CH];

  logic [NUM_CH-1:0] fifo_empty_c, fifo_full_c, push_c;
  logic              pick_found_c;
  logic [CH_W-1:0]   pick_ch_c;
  logic [ENT_W-1:0]  head_c;
  logic              pop_c;

  function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] a, input int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // FIFO status; IDLE and reserved cycle types are accepted but never stored
  always_comb begin
    fifo_empty_c = '0;
    fifo_full_c  = '0;
    push_c       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_empty_c[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full_c[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                        (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
      push_c[i] = bus.in_valid[i] && !fifo_full_c[i] &&
                  ((bus.in_cycle_type[i*4 +: 4] == CT_VALID) ||
                   (bus.in_cycle_type[i*4 +: 4] == CT_DONE));
    end
  end

  assign bus.in_ready = ~fifo_full_c;

  always_comb begin
    pick_found_c = 1'b0;
    pick_ch_c    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!pick_found_c && !fifo_empty_c[ch_add(rr_ptr_q, k)]) begin
        pick_found_c = 1'b1;
        pick_ch_c    = ch_add(rr_ptr_q, k);
      end
    end
  end

  // Arbiter next-state and merged output
  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    rr_ptr_d           = rr_ptr_q;
    pop_c              = 1'b0;
    head_c             = mem_q[grant_q][rd_ptr_q[grant_q][AW-1:0]];
    bus.out_valid      = 1'b0;
    bus.out_cycle_type = '0;
    bus.out_wdat       = '0;
    bus.out_clk_en     = 1'b0;
    bus.out_ch         = '0;
    bus.err_overlen    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_c) begin
          grant_d = pick_ch_c;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        bus.out_valid      = !fifo_empty_c[grant_q];
        bus.out_cycle_type = head_c[ENT_W-1] ? CT_DONE : CT_VALID;
        bus.out_clk_en     = head_c[DATA_W];
        bus.out_wdat       = head_c[DATA_W-1:0];
        bus.out_ch         = grant_q;
        if (bus.out_valid && bus.out_ready) begin
          pop_c = 1'b1;
          if (head_c[ENT_W-1]) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = ch_add(grant_q, 1);
          end else if (beat_cnt_q[grant_q] == CNT_W'(MAX_BEATS - 1)) begin
            bus.err_overlen[grant_q] = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        beat_cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_c[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop_c && (grant_q == CH_W'(i))) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
          if (head_c[ENT_W-1])            beat_cnt_q[i] <= '0;
          else if (beat_cnt_q[i] != '1)   beat_cnt_q[i] <= beat_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_c[i]) begin
        mem_q[i][wr_ptr_q[i][AW-1:0]] <= {(bus.in_cycle_type[i*4 +: 4] == CT_DONE),
                                          bus.in_clk_en[i],
                                          bus.in_wdat[i*DATA_W +: DATA_W]};
      end
    end
  end

`ifdef HERO_WRITE_ARB_STATS_EN
  logic [15:0] txn_cnt_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) txn_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop_c && head_c[ENT_W-1] && (grant_q == CH_W'(i)) && (txn_cnt_q[i] != 16'hFFFF))
          txn_cnt_q[i] <= txn_cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    bus.txn_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) bus.txn_cnt[i*16 +: 16] = txn_cnt_q[i];
  end
`endif
endmodule
